// File: rtl/demux_reg_nch_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer: per-channel
// holding-register state and the default payload width / channel count.
package demux_reg_nch_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_N_CH   = 32;

endpackage : demux_reg_nch_pkg

// File: rtl/demux_ch_slot.sv
// One output channel of the demultiplexer: a single-entry holding register
// with an EMPTY/FULL flag. A load always wins over a pop, so a simultaneous
// pop and load leaves the slot FULL with the new word (zero-bubble).
module demux_ch_slot
    import demux_reg_nch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sink_ready_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: load captures new data, a pop without a load empties the slot
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = CH_FULL;
            data_d  = data_i;
        end else if ((state_q == CH_FULL) && sink_ready_i) begin
            state_d = CH_EMPTY;
        end
    end

    // State and payload registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // The slot can take a word if it is empty or is being drained this cycle
    assign ready_o = (state_q == CH_EMPTY) || sink_ready_i;
    assign valid_o = (state_q == CH_FULL);
    assign data_o  = data_q;

endmodule : demux_ch_slot

// File: rtl/demux_reg_nch.sv
// Registered 1-to-N_CH demultiplexer with per-channel valid/ready handshake.
// Each channel is a one-entry slot; words reach their channel one cycle after
// acceptance. Out-of-range selects are accepted, dropped and flagged on
// sel_err. Optional feature: define DEMUX_BCAST_EN to add an in_bcast input
// that loads every channel at once.
module demux_reg_nch
    import demux_reg_nch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N_CH   = DEFAULT_N_CH,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [DATA_W-1:0]      in_data,
`ifdef DEMUX_BCAST_EN
    input  logic                   in_bcast,
`endif
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic                   sel_err
);

    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    logic            bcastReq;
    logic            selInRange;
    logic            selReady;
    logic            accept;
    logic [N_CH-1:0] slotReady;
    logic [N_CH-1:0] slotLoad;
    logic            selErr_q, selErr_d;

`ifdef DEMUX_BCAST_EN
    assign bcastReq = in_bcast;
`else
    assign bcastReq = 1'b0;
`endif

    assign selInRange = ({1'b0, in_sel} < N_CH_L);

    // Routing: pick the selected slot's readiness, derive in_ready and the
    // per-channel load strobes; in_ready never looks at in_valid
    always_comb begin
        selReady = 1'b0;
        slotLoad = '0;
        for (int k = 0; k < N_CH; k++) begin
            if ({1'b0, in_sel} == (SEL_W+1)'(k)) begin
                selReady = slotReady[k];
            end
        end
        if (bcastReq) begin
            in_ready = &slotReady;
        end else begin
            in_ready = !selInRange || selReady;
        end
        accept = in_valid && in_ready;
        for (int k = 0; k < N_CH; k++) begin
            slotLoad[k] = accept && (bcastReq || ({1'b0, in_sel} == (SEL_W+1)'(k)));
        end
        selErr_d = accept && !bcastReq && !selInRange;
    end

    // Out-of-range flag: a single-cycle pulse following the dropped transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selErr_q <= 1'b0;
        end else begin
            selErr_q <= selErr_d;
        end
    end

    assign sel_err = selErr_q;

    for (genvar g = 0; g < N_CH; g++) begin : gen_slot
        demux_ch_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (slotLoad[g]),
            .data_i       (in_data),
            .sink_ready_i (out_ready[g]),
            .ready_o      (slotReady[g]),
            .valid_o      (out_valid[g]),
            .data_o       (out_data[g*DATA_W +: DATA_W])
        );
    end

endmodule : demux_reg_nch
